// File: rtl/alu_seq_disp.sv
// Registered ALU with a START/BUSY/DONE handshake. Logic and arithmetic ops take one
// cycle, and SLL shifts one bit per cycle. Result and flags are shown on a paged LED bank.
module alu_seq_disp #(
  parameter int WIDTH = 32,
  parameter int LED_W = 8,
  localparam int PAGES = WIDTH / LED_W,
  localparam int SEL_W = (PAGES > 1) ? $clog2(PAGES) : 1,
  localparam int SH_W  = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [2:0]       alu_op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] f_o,
  output logic             of_o,
  output logic             zf_o,
  output logic             cf_o,
  output logic             sf_o,
  input  logic             f_led_sw_i,
  input  logic [SEL_W-1:0] led_sel_i,
  output logic [LED_W-1:0] led_o
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_SLL = 3'b111;

  typedef enum logic [0:0] {S_IDLE, S_EXEC} state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, f_q, f_d;
  logic [SH_W-1:0]  cnt_q, cnt_d;
  logic             of_q, of_d, zf_q, zf_d, cf_q, cf_d, sf_q, sf_d, done_q, done_d;

  logic [WIDTH:0]   sum_ext, diff_ext;
  logic [WIDTH-1:0] b_neg, res;
  logic             res_of, res_cf;

  always_comb begin
    sum_ext  = {1'b0, a_q} + {1'b0, b_q};
    diff_ext = {1'b0, a_q} - {1'b0, b_q};
    b_neg    = ~b_q + {{(WIDTH-1){1'b0}}, 1'b1};
    res      = '0;
    res_of   = 1'b0;
    res_cf   = 1'b0;
    case (op_q)
      OP_AND: res = a_q & b_q;
      OP_OR:  res = a_q | b_q;
      OP_XOR: res = a_q ^ b_q;
      OP_NOR: res = ~(a_q | b_q);
      OP_ADD: begin
        res    = sum_ext[WIDTH-1:0];
        res_cf = sum_ext[WIDTH];
        res_of = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        res    = diff_ext[WIDTH-1:0];
        res_cf = diff_ext[WIDTH];
        res_of = (a_q[WIDTH-1] == b_neg[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SLT: res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      // a_q already carries the earlier shifts; the final edge applies the last one
      OP_SLL: res = (cnt_q == '0) ? a_q : {a_q[WIDTH-2:0], 1'b0};
      default: res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    f_d     = f_q;
    of_d    = of_q;
    zf_d    = zf_q;
    cf_d    = cf_q;
    sf_d    = sf_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_EXEC;
          op_d    = alu_op_i;
          a_d     = a_i;
          b_d     = b_i;
          cnt_d   = b_i[SH_W-1:0];
        end
      end
      S_EXEC: begin
        if (op_q == OP_SLL && cnt_q > {{(SH_W-1){1'b0}}, 1'b1}) begin
          a_d   = {a_q[WIDTH-2:0], 1'b0};
          cnt_d = cnt_q - {{(SH_W-1){1'b0}}, 1'b1};
        end else begin
          state_d = S_IDLE;
          f_d     = res;
          of_d    = res_of;
          cf_d    = res_cf;
          zf_d    = (res == '0);
          sf_d    = res[WIDTH-1];
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      f_q     <= '0;
      of_q    <= 1'b0;
      zf_q    <= 1'b0;
      cf_q    <= 1'b0;
      sf_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      f_q     <= f_d;
      of_q    <= of_d;
      zf_q    <= zf_d;
      cf_q    <= cf_d;
      sf_q    <= sf_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = (state_q == S_EXEC);
  assign done_o = done_q;
  assign f_o    = f_q;
  assign of_o   = of_q;
  assign zf_o   = zf_q;
  assign cf_o   = cf_q;
  assign sf_o   = sf_q;

  logic [LED_W-1:0] led_page, led_flags;

  generate
    if (PAGES == 1) begin : g_one_page
      logic unused_sel;
      assign unused_sel = ^led_sel_i;
      assign led_page   = f_q[LED_W-1:0];
    end else begin : g_pages
      always_comb begin
        led_page = '0;
        for (int p = 0; p < PAGES; p++) begin
          if (led_sel_i == SEL_W'(p)) led_page = f_q[p*LED_W +: LED_W];
        end
      end
    end
  endgenerate

  always_comb begin
    led_flags      = '0;
    led_flags[3:0] = {sf_q, cf_q, of_q, zf_q};
  end

  assign led_o = f_led_sw_i ? led_flags : led_page;

endmodule
